// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_gen
// Description : Radix-4 Booth partial-product generator with a 2-stage
//               valid/ready pipeline feeding wallace_tree. Optional counters
//               are enabled by defining BOOTH_PP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_gen #(
    parameter int MBITS = 12,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MBITS:0]   pp0,
    output logic [MBITS:0]   pp1,
    output logic [MBITS:0]   pp2,
    output logic [MBITS:0]   pp3,
    output logic [NBITS/2-1:0] neg
`ifdef BOOTH_PP_STATS_EN
    ,
    output logic [15:0]      op_count,
    output logic             stall_seen
`endif
);

    localparam int NPP = NBITS / 2;

    logic [NBITS:0]   w_b_ext;
    logic [NPP-1:0]   w_one;
    logic [NPP-1:0]   w_two;
    logic [NPP-1:0]   w_neg;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [MBITS:0]   w_pp [NPP];

    logic             r_s1_valid;
    logic [MBITS-1:0] r_a;
    logic [NPP-1:0]   r_one;
    logic [NPP-1:0]   r_two;
    logic [NPP-1:0]   r_neg;
    logic             r_out_valid;
    logic [MBITS:0]   r_pp [NPP];
    logic [NPP-1:0]   r_pp_neg;

    assign w_b_ext  = {b, 1'b0};
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Digit select: one/two pick |d|, neg is set only for 100/101/110 (111 is zero).
    generate
        for (genvar gi = 0; gi < NPP; gi++) begin : g_enc
            logic [2:0] w_trip;
            assign w_trip    = w_b_ext[2*gi+2 -: 3];
            assign w_one[gi] = w_trip[0] ^ w_trip[1];
            assign w_two[gi] = (w_trip == 3'b011) || (w_trip == 3'b100);
            assign w_neg[gi] = w_trip[2] && !(w_trip[1] && w_trip[0]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NPP; gi++) begin : g_pp
            logic [MBITS:0] w_mag;
            assign w_mag = r_two[gi] ? {r_a, 1'b0} : {r_a[MBITS-1], r_a};
            assign w_pp[gi] = !(r_one[gi] || r_two[gi]) ? '0 :
                              r_neg[gi] ? ~w_mag : w_mag;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_one      <= '0;
            r_two      <= '0;
            r_neg      <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a   <= a;
                r_one <= w_one;
                r_two <= w_two;
                r_neg <= w_neg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pp_neg    <= '0;
            for (int i = 0; i < NPP; i++) begin
                r_pp[i] <= '0;
            end
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_pp_neg <= r_neg;
                for (int i = 0; i < NPP; i++) begin
                    r_pp[i] <= w_pp[i];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign pp0       = r_pp[0];
    assign pp1       = r_pp[1];
    assign pp2       = r_pp[2];
    assign pp3       = r_pp[3];
    assign neg       = r_pp_neg;

`ifdef BOOTH_PP_STATS_EN
    logic [15:0] r_op_count;
    logic        r_stall_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count   <= '0;
            r_stall_seen <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if (r_out_valid && !out_ready) begin
                r_stall_seen <= 1'b1;
            end
        end
    end

    assign op_count   = r_op_count;
    assign stall_seen = r_stall_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_pp_gen
// Description : Directed self-checking bench for booth_pp_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_pp_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] pp0, pp1, pp2, pp3;
    logic [3:0]  neg;
    logic        man_ready = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        rnd_en = 1'b0;
`ifdef BOOTH_PP_STATS_EN
    logic [15:0] op_count;
    logic        stall_seen;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    int          expq[$];
    logic        hold = 1'b0;
    logic [55:0] held = '0;

    booth_pp_gen #(.MBITS(12), .NBITS(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .neg       (neg)
`ifdef BOOTH_PP_STATS_EN
        ,
        .op_count  (op_count),
        .stall_seen(stall_seen)
`endif
    );

    always #5 clk = ~clk;
    assign out_ready = rnd_en ? rnd_ready : man_ready;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int recon(input logic [12:0] p0, input logic [12:0] p1,
                                 input logic [12:0] p2, input logic [12:0] p3,
                                 input logic [3:0] n);
        return (int'($signed(p0)) + int'(n[0]))
             + 4  * (int'($signed(p1)) + int'(n[1]))
             + 16 * (int'($signed(p2)) + int'(n[2]))
             + 64 * (int'($signed(p3)) + int'(n[3]));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: scoreboard on every transfer, stability on every stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold && out_valid) begin
                    check("stall_hold", int'(held == {pp0, pp1, pp2, pp3, neg}), 1);
                end
                hold = out_valid && !out_ready;
                held = {pp0, pp1, pp2, pp3, neg};
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (expq.size() == 0) begin
                        check("unexpected_out", recon(pp0, pp1, pp2, pp3, neg), 32'h7fffffff);
                    end else begin
                        check("prod", recon(pp0, pp1, pp2, pp3, neg), expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] aa, input logic [7:0] bb, input bit keep);
        int t;
        in_valid = 1'b1;
        a = aa;
        b = bb;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (keep) expq.push_back(int'($signed(aa)) * int'($signed(bb)));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [12:0] e0, input logic [12:0] e1,
                              input logic [12:0] e2, input logic [12:0] e3,
                              input logic [3:0] en, input int eprod, output int waited);
        waited = 0;
        while (1) begin
            @(negedge clk);
            waited++;
            if (out_valid) break;
            if (waited > 20) begin
                check({tag, "_timeout"}, 0, 1);
                return;
            end
        end
        check({tag, "_pp0"}, int'(pp0), int'(e0));
        check({tag, "_pp1"}, int'(pp1), int'(e1));
        check({tag, "_pp2"}, int'(pp2), int'(e2));
        check({tag, "_pp3"}, int'(pp3), int'(e3));
        check({tag, "_neg"}, int'(neg), int'(en));
        check({tag, "_recon"}, recon(pp0, pp1, pp2, pp3, neg), eprod);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;
        int t;

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pp0", int'(pp0), 0);
        check("rst_pp3", int'(pp3), 0);
        check("rst_neg", int'(neg), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef BOOTH_PP_STATS_EN
        check("rst_op_count", int'(op_count), 0);
        check("rst_stall_seen", int'(stall_seen), 0);
`endif
        tick();
        rst_n = 1'b1;
        man_ready = 1'b1;
        tick();

        send(12'd5, 8'd1, 1'b1);
        @(negedge clk);
        check("A_lat1", int'(out_valid), 0);
        expect_out("A", 13'd5, 13'd0, 13'd0, 13'd0, 4'b0000, 5, w);
        check("A_latency", w, 1);

        send(12'd5, 8'hFF, 1'b1);
        expect_out("B", 13'h1FFA, 13'd0, 13'd0, 13'd0, 4'b0001, -5, w);

        send(12'h800, 8'h80, 1'b1);
        expect_out("C", 13'd0, 13'd0, 13'd0, 13'h0FFF, 4'b1000, 262144, w);

        // Fill both stages while stalled, then flush them away.
        man_ready = 1'b0;
        send(12'd100, 8'd3, 1'b0);
        send(12'hFF9, 8'hF7, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1;
        a = 12'd1;
        b = 8'd1;
        @(negedge clk);
        check("F_full_ready", int'(in_ready), 0);
        check("F_full_valid", int'(out_valid), 1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("F_out_valid", int'(out_valid), 0);
        check("F_in_ready", int'(in_ready), 1);
`ifdef BOOTH_PP_STATS_EN
        check("F_stall_seen", int'(stall_seen), 1);
`endif
        tick();
        man_ready = 1'b1;
        flush = 1'b1;
        in_valid = 1'b1;
        a = 12'd9;
        b = 8'd9;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("F_drained", int'(out_valid), 0);
        tick();

        // Asynchronous reset with two pairs in flight.
        send(12'd3, 8'd7, 1'b1);
        send(12'hF9C, 8'd55, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("R_out_valid", int'(out_valid), 0);
        check("R_pp0", int'(pp0), 0);
        check("R_pp1", int'(pp1), 0);
        check("R_neg", int'(neg), 0);
        check("R_in_ready", int'(in_ready), 1);
`ifdef BOOTH_PP_STATS_EN
        check("R_op_count", int'(op_count), 0);
        check("R_stall_seen", int'(stall_seen), 0);
`endif
        expq.delete();
        tick();
        rst_n = 1'b1;
        base = n_xfer;
        tick();

        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)), 1'b1);
        end
        t = 0;
        while (expq.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("S_drain", expq.size(), 0);
        check("S_count", n_xfer - base, 20);
`ifdef BOOTH_PP_STATS_EN
        check("S_op_count", int'(op_count), 20);
`endif
        rnd_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
